stream_mux_rr: RTL

- Parametrised N-channel, W-bit stream multiplexer with valid/ready handshake and one registered output stage.
- Successor to the team's gate-level 4:1 bit mux.
- Two modes: fixed select, where `sel` picks the channel, and round-robin arbitration across all valid channels.
- Sits between multiple producer streams and a single consumer; reports which channel each output beat came from.

---
 rtl/stream_mux_rr_if.sv | 26 ++
 rtl/stream_mux_rr.sv | 93 +++++++++
 2 files changed

// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N producers and one consumer of the round-robin stream mux.
// The slave modport is the mux; the master modport is the surrounding producers/consumer.
interface stream_mux_rr_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux, fixed-select or round-robin, one registered output stage (1-cycle latency).
// in_ready is combinational; a stalled output holds its beat and blocks all inputs until drained.
module stream_mux_rr #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  stream_mux_rr_if.slave   bus
);
  localparam logic [SEL_W:0]   CH_L   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]    rr_ptr;
  logic [WIDTH-1:0]    out_data_q;
  logic [SEL_W-1:0]    out_chan_q;
  logic                out_valid_q;

  logic                load_ok;
  logic [CHANNELS-1:0] grant;
  logic                found;
  logic [SEL_W:0]      scan;
  logic [CHANNELS-1:0] rdy;
  logic [CHANNELS-1:0] acc;
  logic                acc_any;
  logic [SEL_W-1:0]    acc_idx;
  logic [WIDTH-1:0]    acc_dat;
  logic [SEL_W-1:0]    next_ptr;

  assign load_ok = !out_valid_q || bus.out_ready;

  // An out-of-range sel matches no channel, so nothing is granted rather than stalling.
  always_comb begin
    grant = '0;
    found = 1'b0;
    scan  = '0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i)) grant[i] = 1'b1;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        scan = {1'b0, rr_ptr} + (SEL_W+1)'(k);
        if (scan >= CH_L) scan = scan - CH_L;
        if (!found && bus.in_valid[scan]) begin
          grant[scan] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  assign rdy          = grant & {CHANNELS{load_ok & rst_n}};
  assign bus.in_ready = rdy;
  assign acc          = bus.in_valid & rdy;
  assign acc_any      = |acc;

  always_comb begin
    acc_idx = '0;
    acc_dat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (acc[i]) begin
        acc_idx = SEL_W'(i);
        acc_dat = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign next_ptr = (acc_idx == LAST_CH) ? '0 : acc_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr      <= '0;
    end else if (acc_any) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_dat;
      out_chan_q  <= acc_idx;
      if (mode) rr_ptr <= next_ptr;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
endmodule
